dispatch_ctrl: RTL and testbench

//  Sits between the instruction queue and the back end; sequences every dispatch.

---
 rtl/dispatch_ctrl_pkg.sv | 19 +
 rtl/dispatch_ctrl_rob_tag_alloc.sv | 61 ++++++
 rtl/dispatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_dispatch_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch stage.
//   OP_NOP        opcode that is never accepted from the instruction queue
//   disp_state_t  dispatch sequencer states {ST_RUN, ST_STALL, ST_FLUSH}
//   is_mem_op()   memory-class decode: opcodes 5'b10xxx go to the load/store buffer
package dispatch_ctrl_pkg;

    localparam logic [4:0] OP_NOP = 5'h1F;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } disp_state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/dispatch_ctrl_rob_tag_alloc.sv
// ROB tag allocator: hands out tags 0..ROB_DEPTH-1 in order and tracks how many
// ROB entries are free.
//   clk, rst     clock, synchronous active-low reset
//   fire         one instruction dispatched this cycle (consumes a tag and an entry)
//   commit       one ROB entry retired this cycle
//   flush        pipeline flush: tag returns to 0, all entries free
//   next_tag     tag for the next dispatched instruction
//   rob_free     number of free ROB entries (0..ROB_DEPTH)
module rob_tag_alloc #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  logic             commit,
    input  logic             flush,
    output logic [TAG_W-1:0] next_tag,
    output logic [TAG_W:0]   rob_free
);
    localparam logic [TAG_W:0]   FREE_MAX = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(ROB_DEPTH - 1);

    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [TAG_W:0]   free_reg, free_next;
    logic             commit_eff;

    always_comb begin
        // A commit with nothing outstanding has nothing to retire.
        commit_eff = commit && (free_reg != FREE_MAX);
        tag_next   = tag_reg;
        free_next  = free_reg;
        if (flush) begin
            tag_next  = '0;
            free_next = FREE_MAX;
        end else begin
            if (fire) begin
                tag_next = (tag_reg == TAG_LAST) ? '0 : tag_reg + TAG_W'(1);
            end
            if (fire && !commit_eff) begin
                free_next = free_reg - (TAG_W+1)'(1);
            end else if (!fire && commit_eff) begin
                free_next = free_reg + (TAG_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_reg  <= '0;
            free_reg <= FREE_MAX;
        end else begin
            tag_reg  <= tag_next;
            free_reg <= free_next;
        end
    end

    assign next_tag = tag_reg;
    assign rob_free = free_reg;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: takes one decoded instruction per cycle from the
// instruction queue into a one-entry hold register, steers it to the ALU
// reservation station or the load/store buffer, allocates a ROB tag and
// drains on flush.
//   clk, rst                  clock, synchronous active-low reset
//   iq_valid/iq_op/...        instruction offered by the IQ; iq_ready accepts it
//   alu_rs_full, lsb_full     back-end back-pressure
//   rob_commit                one ROB entry retired
//   flush                     pipeline flush
//   alu_valid, lsb_valid      dispatch strobe for each target
//   disp_*                    hold-register contents, disp_tag = allocated ROB tag
//   rob_free                  free ROB entries
//   stall_cycles              saturating count of cycles spent stalled
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH    = 8,
    parameter int TAG_W        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iq_valid,
    input  logic [4:0]       iq_op,
    input  logic [4:0]       iq_rs1,
    input  logic [4:0]       iq_rs2,
    input  logic [4:0]       iq_rd,
    input  logic [31:0]      iq_imm,
    input  logic             iq_has_imm,
    output logic             iq_ready,
    input  logic             alu_rs_full,
    input  logic             lsb_full,
    input  logic             rob_commit,
    input  logic             flush,
    output logic             alu_valid,
    output logic             lsb_valid,
    output logic [4:0]       disp_op,
    output logic [4:0]       disp_rs1,
    output logic [4:0]       disp_rs2,
    output logic [4:0]       disp_rd,
    output logic [31:0]      disp_imm,
    output logic             disp_has_imm,
    output logic [TAG_W-1:0] disp_tag,
    output logic [TAG_W:0]   rob_free,
    output logic [31:0]      stall_cycles
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    // Counter holds the remaining FLUSH cycles minus one.
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    disp_state_t     state_reg, state_next;
    logic [FC_W-1:0] flush_cnt_reg, flush_cnt_next;

    logic        hold_v_reg;
    logic [4:0]  hold_op_reg, hold_rs1_reg, hold_rs2_reg, hold_rd_reg;
    logic [31:0] hold_imm_reg;
    logic        hold_has_imm_reg;
    logic [31:0] stall_cnt_reg;

    logic is_mem, slot_free, fire, accept;

    always_comb begin
        is_mem    = is_mem_op(hold_op_reg);
        slot_free = is_mem ? !lsb_full : !alu_rs_full;
        // rst gating keeps every strobe low during the first reset cycle,
        // before the hold register has been cleared.
        fire      = rst && hold_v_reg && (rob_free != '0) && slot_free
                    && (state_reg != ST_FLUSH) && !flush;
        iq_ready  = rst && (state_reg != ST_FLUSH) && !flush && (!hold_v_reg || fire);
        accept    = iq_valid && iq_ready && (iq_op != OP_NOP);
        alu_valid = fire && !is_mem;
        lsb_valid = fire && is_mem;

        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        if (flush) begin
            // Also reloads the drain counter when already flushing.
            state_next     = ST_FLUSH;
            flush_cnt_next = FLUSH_LOAD;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (hold_v_reg && !fire) state_next = ST_STALL;
                end
                ST_STALL: begin
                    if (fire) state_next = ST_RUN;
                end
                ST_FLUSH: begin
                    if (flush_cnt_reg == '0) state_next = ST_RUN;
                    else flush_cnt_next = flush_cnt_reg - FC_W'(1);
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            if (state_reg == ST_STALL && stall_cnt_reg != 32'hFFFF_FFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_v_reg       <= 1'b0;
            hold_op_reg      <= OP_NOP;
            hold_rs1_reg     <= '0;
            hold_rs2_reg     <= '0;
            hold_rd_reg      <= '0;
            hold_imm_reg     <= '0;
            hold_has_imm_reg <= 1'b0;
        end else if (flush) begin
            hold_v_reg <= 1'b0;
        end else if (accept) begin
            // Covers fire+accept in the same cycle: contents replaced, stays valid.
            hold_v_reg       <= 1'b1;
            hold_op_reg      <= iq_op;
            hold_rs1_reg     <= iq_rs1;
            hold_rs2_reg     <= iq_rs2;
            hold_rd_reg      <= iq_rd;
            hold_imm_reg     <= iq_imm;
            hold_has_imm_reg <= iq_has_imm;
        end else if (fire) begin
            hold_v_reg <= 1'b0;
        end
    end

    rob_tag_alloc #(
        .ROB_DEPTH(ROB_DEPTH),
        .TAG_W    (TAG_W)
    ) u_tag_alloc (
        .clk     (clk),
        .rst     (rst),
        .fire    (fire),
        .commit  (rob_commit),
        .flush   (flush),
        .next_tag(disp_tag),
        .rob_free(rob_free)
    );

    assign disp_op      = hold_op_reg;
    assign disp_rs1     = hold_rs1_reg;
    assign disp_rs2     = hold_rs2_reg;
    assign disp_rd      = hold_rd_reg;
    assign disp_imm     = hold_imm_reg;
    assign disp_has_imm = hold_has_imm_reg;
    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
    localparam int ROB_DEPTH    = 8;
    localparam int TAG_W        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             iq_valid;
    logic [4:0]       iq_op, iq_rs1, iq_rs2, iq_rd;
    logic [31:0]      iq_imm;
    logic             iq_has_imm;
    logic             iq_ready;
    logic             alu_rs_full, lsb_full, rob_commit, flush;
    logic             alu_valid, lsb_valid;
    logic [4:0]       disp_op, disp_rs1, disp_rs2, disp_rd;
    logic [31:0]      disp_imm;
    logic             disp_has_imm;
    logic [TAG_W-1:0] disp_tag;
    logic [TAG_W:0]   rob_free;
    logic [31:0]      stall_cycles;

    always #5 clk = ~clk;

    dispatch_ctrl #(
        .ROB_DEPTH   (ROB_DEPTH),
        .TAG_W       (TAG_W),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .iq_valid(iq_valid), .iq_op(iq_op), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2),
        .iq_rd(iq_rd), .iq_imm(iq_imm), .iq_has_imm(iq_has_imm), .iq_ready(iq_ready),
        .alu_rs_full(alu_rs_full), .lsb_full(lsb_full), .rob_commit(rob_commit),
        .flush(flush), .alu_valid(alu_valid), .lsb_valid(lsb_valid),
        .disp_op(disp_op), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd),
        .disp_imm(disp_imm), .disp_has_imm(disp_has_imm), .disp_tag(disp_tag),
        .rob_free(rob_free), .stall_cycles(stall_cycles)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a slot, an outstanding-instruction count, a fire count
    // since the last flush, and the number of drain cycles still to go.
    bit          m_hold_v;
    logic [4:0]  m_op, m_rs1, m_rs2, m_rd;
    logic [31:0] m_imm;
    bit          m_has_imm;
    int          m_outstanding;
    int          m_fires;
    int          m_flush_left;
    bit          m_waiting;
    longint      m_stall;

    task automatic model_reset();
        m_hold_v = 0; m_op = 5'h1F; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_has_imm = 0;
        m_outstanding = 0; m_fires = 0; m_flush_left = 0; m_waiting = 0; m_stall = 0;
    endtask

    task automatic step(input bit r, input bit v, input logic [4:0] op,
                        input bit af, input bit lf, input bit cm, input bit fl);
        bit m_mem, m_fire, m_ready, m_accept, new_waiting;
        int free;
        logic [4:0]  f_rs1, f_rs2, f_rd;
        logic [31:0] f_imm;
        bit          f_has_imm;
        f_rs1 = 5'($urandom); f_rs2 = 5'($urandom); f_rd = 5'($urandom);
        f_imm = $urandom; f_has_imm = 1'($urandom);
        rst = r; iq_valid = v; iq_op = op; iq_rs1 = f_rs1; iq_rs2 = f_rs2; iq_rd = f_rd;
        iq_imm = f_imm; iq_has_imm = f_has_imm;
        alu_rs_full = af; lsb_full = lf; rob_commit = cm; flush = fl;
        @(negedge clk);
        free     = ROB_DEPTH - m_outstanding;
        m_mem    = (m_op >= 5'h10) && (m_op <= 5'h17);
        m_fire   = r && m_hold_v && (free > 0) && (m_mem ? !lf : !af) && (m_flush_left == 0) && !fl;
        m_ready  = r && (m_flush_left == 0) && !fl && (!m_hold_v || m_fire);
        m_accept = v && m_ready && (op != 5'h1F);
        check_eq("iq_ready",     64'(iq_ready),     64'(m_ready));
        check_eq("alu_valid",    64'(alu_valid),    64'(m_fire && !m_mem));
        check_eq("lsb_valid",    64'(lsb_valid),    64'(m_fire && m_mem));
        check_eq("disp_tag",     64'(disp_tag),     64'(m_fires % ROB_DEPTH));
        check_eq("rob_free",     64'(rob_free),     64'(free));
        check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        check_eq("disp_op",      64'(disp_op),      64'(m_op));
        check_eq("disp_regs",    64'({disp_rs1, disp_rs2, disp_rd, disp_has_imm}),
                                 64'({m_rs1, m_rs2, m_rd, m_has_imm}));
        check_eq("disp_imm",     64'(disp_imm),     64'(m_imm));
        if (m_fire)
            $display("[TB] dispatch %s tag=%0d op=%02h rob_free=%0d",
                     m_mem ? "lsb" : "alu", m_fires % ROB_DEPTH, m_op, free - 1);
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (m_waiting && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (fl) begin
                m_hold_v = 0; m_outstanding = 0; m_fires = 0;
                m_flush_left = FLUSH_CYCLES; m_waiting = 0;
            end else begin
                new_waiting = m_hold_v && !m_fire;
                m_outstanding = m_outstanding + (m_fire ? 1 : 0)
                                - ((cm && m_outstanding > 0) ? 1 : 0);
                if (m_fire) m_fires++;
                if (m_flush_left > 0) m_flush_left--;
                if (m_accept) begin
                    m_hold_v = 1; m_op = op; m_rs1 = f_rs1; m_rs2 = f_rs2; m_rd = f_rd;
                    m_imm = f_imm; m_has_imm = f_has_imm;
                end else if (m_fire) begin
                    m_hold_v = 0;
                end
                m_waiting = new_waiting;
            end
        end
        #1;
    endtask

    initial begin
        bit r, v, af, lf, cm, fl;
        logic [4:0] op;
        rst = 0; iq_valid = 0; iq_op = 5'h1F; iq_rs1 = 0; iq_rs2 = 0; iq_rd = 0;
        iq_imm = 0; iq_has_imm = 0; alu_rs_full = 0; lsb_full = 0; rob_commit = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset held, with traffic and flush present
        step(0, 1, 5'h01, 0, 0, 0, 1);
        step(0, 1, 5'h12, 0, 0, 1, 0);
        // Commit with every ROB entry free is ignored
        step(1, 0, 5'h1F, 0, 0, 1, 0);

        // Streaming ALU ops
        repeat (4) step(1, 1, 5'h01, 0, 0, 0, 0);
        repeat (2) step(1, 0, 5'h1F, 0, 0, 0, 0);

        // Memory op held by a full LSB, then released
        step(1, 1, 5'h12, 0, 1, 0, 0);
        repeat (3) step(1, 0, 5'h1F, 0, 1, 0, 0);
        repeat (2) step(1, 0, 5'h1F, 0, 0, 0, 0);

        // Clear, then fill the ROB and keep offering
        step(1, 0, 5'h1F, 0, 0, 0, 1);
        repeat (3) step(1, 0, 5'h1F, 0, 0, 0, 0);
        repeat (11) step(1, 1, 5'h01, 0, 0, 0, 0);
        step(1, 0, 5'h1F, 0, 0, 1, 0);
        repeat (3) step(1, 1, 5'h03, 0, 0, 1, 0);
        repeat (2) step(1, 0, 5'h1F, 0, 0, 0, 0);

        // Flush mid-stream with a held instruction, then flush again while draining
        repeat (3) step(1, 1, 5'h01, 0, 0, 1, 0);
        step(1, 1, 5'h02, 1, 0, 0, 0);
        step(1, 1, 5'h02, 1, 0, 0, 1);
        step(1, 1, 5'h02, 0, 0, 0, 0);
        step(1, 1, 5'h02, 0, 0, 0, 1);
        repeat (4) step(1, 1, 5'h15, 0, 0, 0, 0);

        // NOP filter
        repeat (3) step(1, 1, 5'h1F, 0, 0, 0, 0);

        // Reset together with flush, mid-stream
        step(1, 1, 5'h01, 1, 0, 0, 0);
        step(0, 1, 5'h01, 0, 0, 0, 1);
        repeat (3) step(1, 1, 5'h01, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: op = 5'h01;
                1: op = 5'h12;
                2: op = 5'h1F;
                default: op = 5'($urandom);
            endcase
            af = ($urandom_range(0, 3) == 0);
            lf = ($urandom_range(0, 3) == 0);
            cm = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 39) == 0);
            step(r, v, op, af, lf, cm, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
